// File: rtl/regfile_scoreboard.sv
// RV32I architectural register file with write-through WB bypass and a per-register
// pending-write scoreboard that drives the decode stall.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNTW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            hazard,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            rd_full,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            kill_valid,
  input  logic [4:0]      kill_rd,
  output logic            sb_err
);

  localparam int SW = CNTW + 2;
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic [XLEN-1:0] regs    [NREG];
  logic [CNTW-1:0] cnt     [NREG];
  logic [CNTW-1:0] cnt_nxt [NREG];
  logic            underflow;
  logic            pend1, pend2;
  logic            wb_hit1, wb_hit2;

  assign wb_hit1 = wb_valid && (wb_rd == rs1_addr);
  assign wb_hit2 = wb_valid && (wb_rd == rs2_addr);

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : (wb_hit1 ? wb_data : regs[rs1_addr]);
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : (wb_hit2 ? wb_data : regs[rs2_addr]);

  // Full is judged on the current count, before this cycle's writeback/kill decrements.
  assign rd_full = (issue_rd != 5'd0) && (cnt[issue_rd] == CNT_MAX);

  // A single outstanding write retiring this very cycle is covered by the bypass.
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    if (rs1_addr != 5'd0)
      pend1 = (cnt[rs1_addr] > CNT_ONE) || ((cnt[rs1_addr] == CNT_ONE) && !wb_hit1);
    if (rs2_addr != 5'd0)
      pend2 = (cnt[rs2_addr] > CNT_ONE) || ((cnt[rs2_addr] == CNT_ONE) && !wb_hit2);
  end

  assign hazard = (rs1_used && pend1) || (rs2_used && pend2) || (issue_valid && rd_full);

  always_comb begin
    logic          inc, dec_wb, dec_kill;
    logic [SW-1:0] sum;
    // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
    underflow  = 1'b0;
    inc        = 1'b0;
    dec_wb     = 1'b0;
    dec_kill   = 1'b0;
    sum        = '0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      inc      = issue_valid && (issue_rd == 5'(r)) && !rd_full;
      dec_wb   = wb_valid && (wb_rd == 5'(r));
      dec_kill = kill_valid && (kill_rd == 5'(r));
      sum      = SW'(cnt[r]) + SW'(inc) - SW'(dec_wb) - SW'(dec_kill);
      if (sum[SW-1]) begin
        cnt_nxt[r] = '0;
        underflow  = 1'b1;
      end else begin
        cnt_nxt[r] = sum[CNTW-1:0];
      end
    end
  end

  // NOTE: the register array is reset too, because software may read registers it never wrote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      sb_err <= 1'b0;
    end else begin
      if (wb_valid && (wb_rd != 5'd0))
        regs[wb_rd] <= wb_data;
      for (int i = 0; i < NREG; i++)
        cnt[i] <= cnt_nxt[i];
      if (underflow || (issue_valid && rd_full))
        sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: inputs change just after the falling edge and
// combinational outputs are sampled 1 ns later, well away from the rising edge.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd, kill_rd;
  logic        rs1_used, rs2_used, issue_valid, wb_valid, kill_valid;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        hazard, rd_full, sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .CNTW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .hazard(hazard),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rd_full(rd_full),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and return all inputs to idle.
  task automatic next_cycle();
    @(negedge clk);
    rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    kill_valid = 1'b0; kill_rd = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0; rs1_used = 1'b0; rs2_used = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    kill_valid = 1'b0; kill_rd = '0;
    #1;
    check("reset_rs1_data", rs1_data, 32'h0);
    check("reset_hazard",   hazard,   1'b0);
    check("reset_rd_full",  rd_full,  1'b0);
    check("reset_sb_err",   sb_err,   1'b0);

    next_cycle();
    rst_n = 1'b1;

    // 1: every register reads zero after reset; x0 ignores writes.
    for (int a = 1; a < 32; a++) begin
      next_cycle();
      rs1_addr = 5'(a); rs2_addr = 5'(a); rs1_used = 1'b1; rs2_used = 1'b1;
      #1;
      check($sformatf("t1_rs1_x%0d", a), rs1_data, 32'h0);
      check($sformatf("t1_rs2_x%0d", a), rs2_data, 32'h0);
      check($sformatf("t1_haz_x%0d", a), hazard,   1'b0);
    end
    next_cycle();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h5; rs1_addr = 5'd0; rs1_used = 1'b1;
    #1;
    check("t1_x0_bypass", rs1_data, 32'h0);
    next_cycle();
    rs1_addr = 5'd0; rs1_used = 1'b1;
    #1;
    check("t1_x0_read",   rs1_data, 32'h0);
    check("t1_x0_sb_err", sb_err,   1'b0);

    // 2: bypass on the writeback cycle, then the stored value.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd3;
    #1;
    check("t2_issue_full", rd_full, 1'b0);
    next_cycle();
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF; rs1_addr = 5'd3; rs1_used = 1'b1;
    #1;
    check("t2_bypass",     rs1_data, 32'hDEADBEEF);
    check("t2_bypass_haz", hazard,   1'b0);
    next_cycle();
    rs1_addr = 5'd3; rs1_used = 1'b1; rs2_addr = 5'd3;
    #1;
    check("t2_reg_rs1", rs1_data, 32'hDEADBEEF);
    check("t2_reg_rs2", rs2_data, 32'hDEADBEEF);
    check("t2_haz",     hazard,   1'b0);

    // 3: RAW stall until writeback, resolved by bypass.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd5; rs2_addr = 5'd5; rs2_used = 1'b1;
    #1;
    check("t3_issue_cycle_haz", hazard, 1'b0);
    next_cycle();
    rs2_addr = 5'd5; rs2_used = 1'b1;
    #1;
    check("t3_pending_haz", hazard, 1'b1);
    rs2_used = 1'b0;
    #1;
    check("t3_unused_haz", hazard, 1'b0);
    next_cycle();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h7; rs2_addr = 5'd5; rs2_used = 1'b1;
    #1;
    check("t3_wb_haz",  hazard,   1'b0);
    check("t3_wb_data", rs2_data, 32'h7);
    next_cycle();
    rs2_addr = 5'd5; rs2_used = 1'b1;
    #1;
    check("t3_drained_haz", hazard,   1'b0);
    check("t3_reg_data",    rs2_data, 32'h7);

    // 5: simultaneous issue and writeback on the same register nets out.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h11; rs1_addr = 5'd7; rs1_used = 1'b1;
    #1;
    check("t5_haz_same_cycle", hazard,   1'b0);
    check("t5_bypass",         rs1_data, 32'h11);
    next_cycle();
    rs1_addr = 5'd7; rs1_used = 1'b1;
    #1;
    check("t5_cnt_still_1", hazard, 1'b1);
    next_cycle();
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h12;
    next_cycle();
    rs1_addr = 5'd7; rs1_used = 1'b1;
    #1;
    check("t5_drained", hazard, 1'b0);

    // 6: writeback and kill together remove two pending writes.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd8;
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd8;
    next_cycle();
    wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'h88; kill_valid = 1'b1; kill_rd = 5'd8;
    rs1_addr = 5'd8; rs1_used = 1'b1;
    #1;
    check("t6_two_pending_haz", hazard,   1'b1);
    check("t6_bypass",          rs1_data, 32'h88);
    next_cycle();
    rs1_addr = 5'd8; rs1_used = 1'b1;
    #1;
    check("t6_cnt_zero",  hazard, 1'b0);
    check("t6_no_err",    sb_err, 1'b0);

    // 4: counter saturates at 3; a fourth issue is refused and flagged.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      issue_valid = 1'b1; issue_rd = 5'd6;
      #1;
      check($sformatf("t4_not_full_%0d", k), rd_full, 1'b0);
    end
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd6;
    #1;
    check("t4_full",        rd_full, 1'b1);
    check("t4_full_hazard", hazard,  1'b1);
    next_cycle();
    issue_rd = 5'd6;
    #1;
    check("t4_sb_err",    sb_err,  1'b1);
    check("t4_held_full", rd_full, 1'b1);
    next_cycle();
    issue_rd = 5'd6; wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    #1;
    check("t4_full_before_dec", rd_full, 1'b1);
    next_cycle();
    issue_rd = 5'd6;
    #1;
    check("t4_after_dec", rd_full, 1'b0);

    // Mid-pipeline reset discards pending state, data and the error flag.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd6;
    next_cycle();
    issue_valid = 1'b1; issue_rd = 5'd10;
    next_cycle();
    issue_rd = 5'd6; rs1_addr = 5'd10; rs1_used = 1'b1; rs2_addr = 5'd3;
    #1;
    check("rst_pre_full", rd_full,  1'b1);
    check("rst_pre_haz",  hazard,   1'b1);
    check("rst_pre_data", rs2_data, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check("rst_full", rd_full,  1'b0);
    check("rst_haz",  hazard,   1'b0);
    check("rst_data", rs2_data, 32'h0);
    check("rst_err",  sb_err,   1'b0);
    next_cycle();
    rst_n = 1'b1;

    // Underflow: kill on x0 is ignored, on an idle register it is flagged.
    next_cycle();
    kill_valid = 1'b1; kill_rd = 5'd0;
    next_cycle();
    #1;
    check("uf_x0_no_err", sb_err, 1'b0);
    next_cycle();
    kill_valid = 1'b1; kill_rd = 5'd9;
    next_cycle();
    rs1_addr = 5'd9; rs1_used = 1'b1;
    #1;
    check("uf_err",     sb_err, 1'b1);
    check("uf_cnt_haz", hazard, 1'b0);
    next_cycle();
    wb_valid = 1'b1; wb_rd = 5'd12; wb_data = 32'hA5A50012;
    next_cycle();
    rs2_addr = 5'd12;
    #1;
    check("uf_data_path", rs2_data, 32'hA5A50012);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
